// File: rtl/rx_link_monitor.sv
// rx_link_monitor: per-lane 8b/10b receive link monitor.
// Each lane runs its own LOS/ACQ/SYNC comma-lock FSM with a leaky error
// accumulator that drops the lane out of sync on sustained errors.
// Optional per-lane saturating error counters are built only when
// RX_LINK_MON_ERR_CNT_EN is defined. Otherwise ErrCount reads zero and
// CntClr is ignored. The port list is the same in both builds.

// Per-lane lock FSM. All state advances only on cycles with rxValid high.
module rx_link_monitor_lane #(
    parameter int LOCK_COMMAS = 4,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_SYMS   = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       rxValid,
    input  logic [7:0] rxSym,
    input  logic       rxK,
    input  logic       decErr,
    input  logic       dispErr,
    output logic       symErr,
    output logic       laneSync,
    output logic       lossOfSync
);
    localparam int CCW = $clog2(LOCK_COMMAS + 1);
    localparam int AW  = $clog2(ERR_LIMIT + 1);
    localparam int RW  = $clog2(GOOD_SYMS + 1);

    localparam logic [CCW-1:0] LOCK_V = CCW'(LOCK_COMMAS);
    localparam logic [AW-1:0]  ERR_V  = AW'(ERR_LIMIT);
    localparam logic [RW-1:0]  GOOD_V = RW'(GOOD_SYMS);

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } lockStateT;

    lockStateT      state, stateNxt;
    logic [CCW-1:0] commaCnt, commaCntNxt;
    logic [AW-1:0]  acc, accNxt;
    logic [RW-1:0]  run, runNxt;
    logic           lossNxt;
    logic           comma;

    // An error on a valid symbol never counts as a comma.
    assign symErr = rxValid & (decErr | dispErr);
    assign comma  = rxValid & rxK & (rxSym == 8'hBC) & ~symErr;

    // State, counters and the registered output decode.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= LOS;
            commaCnt   <= '0;
            acc        <= '0;
            run        <= '0;
            laneSync   <= 1'b0;
            lossOfSync <= 1'b0;
        end else begin
            state      <= stateNxt;
            commaCnt   <= commaCntNxt;
            acc        <= accNxt;
            run        <= runNxt;
            laneSync   <= (stateNxt == SYNC);
            lossOfSync <= lossNxt;
        end
    end

    // Next-state logic; an idle cycle (rxValid low) holds everything.
    always_comb begin
        stateNxt    = state;
        commaCntNxt = commaCnt;
        accNxt      = acc;
        runNxt      = run;
        lossNxt     = 1'b0;
        if (rxValid) begin
            unique case (state)
                LOS: begin
                    if (comma) begin
                        if (LOCK_COMMAS <= 1) begin
                            stateNxt    = SYNC;
                            commaCntNxt = '0;
                            accNxt      = '0;
                            runNxt      = '0;
                        end else begin
                            stateNxt    = ACQ;
                            commaCntNxt = CCW'(1);
                        end
                    end
                end
                ACQ: begin
                    if (symErr) begin
                        stateNxt    = LOS;
                        commaCntNxt = '0;
                    end else if (comma) begin
                        if (commaCnt + CCW'(1) == LOCK_V) begin
                            stateNxt    = SYNC;
                            commaCntNxt = '0;
                            accNxt      = '0;
                            runNxt      = '0;
                        end else begin
                            commaCntNxt = commaCnt + CCW'(1);
                        end
                    end
                end
                SYNC: begin
                    if (symErr) begin
                        // Error wins over a coinciding run completion.
                        runNxt = '0;
                        if (acc + AW'(1) == ERR_V) begin
                            stateNxt = LOS;
                            accNxt   = '0;
                            lossNxt  = 1'b1;
                        end else begin
                            accNxt = acc + AW'(1);
                        end
                    end else if (run + RW'(1) == GOOD_V) begin
                        runNxt = '0;
                        if (acc != '0) begin
                            accNxt = acc - AW'(1);
                        end
                    end else begin
                        runNxt = run + RW'(1);
                    end
                end
                default: begin
                    stateNxt    = LOS;
                    commaCntNxt = '0;
                    accNxt      = '0;
                    runNxt      = '0;
                end
            endcase
        end
    end
endmodule

// Top: LANES independent lane monitors plus the shared AllSync and counters.
module rx_link_monitor #(
    parameter int LANES       = 4,
    parameter int LOCK_COMMAS = 4,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_SYMS   = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   RxBitCLK_10,
    input  logic                   Reset,
    input  logic [LANES-1:0]       RxValid,
    input  logic [8*LANES-1:0]     RxParallel_8,
    input  logic [LANES-1:0]       RxDataK,
    input  logic [LANES-1:0]       Decode_Error,
    input  logic [LANES-1:0]       Disparity_Error,
    input  logic                   CntClr,
    output logic [LANES-1:0]       LaneSync,
    output logic                   AllSync,
    output logic [LANES-1:0]       LossOfSync,
    output logic [CNT_W*LANES-1:0] ErrCount
);
    logic [LANES-1:0] symErr;

    for (genvar i = 0; i < LANES; i++) begin : gLane
        rx_link_monitor_lane #(
            .LOCK_COMMAS (LOCK_COMMAS),
            .ERR_LIMIT   (ERR_LIMIT),
            .GOOD_SYMS   (GOOD_SYMS)
        ) uLane (
            .clk        (RxBitCLK_10),
            .rstN       (Reset),
            .rxValid    (RxValid[i]),
            .rxSym      (RxParallel_8[8*i +: 8]),
            .rxK        (RxDataK[i]),
            .decErr     (Decode_Error[i]),
            .dispErr    (Disparity_Error[i]),
            .symErr     (symErr[i]),
            .laneSync   (LaneSync[i]),
            .lossOfSync (LossOfSync[i])
        );
    end

    // Combinational AND so AllSync tracks LaneSync with no added latency.
    assign AllSync = &LaneSync;

`ifdef RX_LINK_MON_ERR_CNT_EN
    logic [LANES-1:0][CNT_W-1:0] errCnt;

    // Saturating per-lane error counters; clear beats a same-cycle error.
    always_ff @(posedge RxBitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            errCnt <= '0;
        end else if (CntClr) begin
            errCnt <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (symErr[i] && (errCnt[i] != {CNT_W{1'b1}})) begin
                    errCnt[i] <= errCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign ErrCount = errCnt;
`else
    logic unusedCntSrc;

    assign ErrCount     = '0;
    assign unusedCntSrc = ^{CntClr, symErr};
`endif
endmodule

// File: tb/tb_rx_link_monitor.sv
// Self-checking bench for rx_link_monitor: directed lock/loss scenarios
// followed by a randomized phase, all checked against a behavioural model.
module tb_rx_link_monitor;
    localparam int LANES = 4;
    localparam int LOCK  = 4;
    localparam int ELIM  = 4;
    localparam int GOOD  = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic                   clk  = 1'b0;
    logic                   rstN = 1'b1;
    logic [LANES-1:0]       valid = '0, k = '0, dec = '0, disp = '0;
    logic [8*LANES-1:0]     data = '0;
    logic                   clr = 1'b0;
    logic [LANES-1:0]       laneSync, loss;
    logic                   allSync;
    logic [CW*LANES-1:0]    errCount;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: lock flag, comma progress, leaky error level,
    // clean-run length and raw error tally per lane.
    bit mLock[LANES];
    bit mLoss[LANES];
    int mCommas[LANES];
    int mAcc[LANES];
    int mRun[LANES];
    int mErr[LANES];

    rx_link_monitor #(
        .LANES(LANES), .LOCK_COMMAS(LOCK), .ERR_LIMIT(ELIM),
        .GOOD_SYMS(GOOD), .CNT_W(CW)
    ) dut (
        .RxBitCLK_10     (clk),
        .Reset           (rstN),
        .RxValid         (valid),
        .RxParallel_8    (data),
        .RxDataK         (k),
        .Decode_Error    (dec),
        .Disparity_Error (disp),
        .CntClr          (clr),
        .LaneSync        (laneSync),
        .AllSync         (allSync),
        .LossOfSync      (loss),
        .ErrCount        (errCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    function automatic void modelReset();
        for (int i = 0; i < LANES; i++) begin
            mLock[i] = 0; mLoss[i] = 0; mCommas[i] = 0;
            mAcc[i] = 0; mRun[i] = 0; mErr[i] = 0;
        end
    endfunction

    function automatic void modelStep(logic [LANES-1:0] v, logic [LANES-1:0] kk,
                                      logic [LANES-1:0] de, logic [LANES-1:0] di,
                                      logic [8*LANES-1:0] d, logic c);
        for (int i = 0; i < LANES; i++) begin
            bit err;
            bit isComma;
            mLoss[i] = 0;
            if (v[i]) begin
                err     = de[i] | di[i];
                isComma = kk[i] && (d[8*i +: 8] == 8'hBC) && !err;
                if (err && mErr[i] < CMAX) mErr[i]++;
                if (mLock[i]) begin
                    if (err) begin
                        mRun[i] = 0;
                        mAcc[i]++;
                        if (mAcc[i] >= ELIM) begin
                            mLock[i] = 0; mLoss[i] = 1; mAcc[i] = 0;
                        end
                    end else begin
                        mRun[i]++;
                        if (mRun[i] == GOOD) begin
                            mRun[i] = 0;
                            if (mAcc[i] > 0) mAcc[i]--;
                        end
                    end
                end else if (err) begin
                    mCommas[i] = 0;
                end else if (isComma) begin
                    mCommas[i]++;
                    if (mCommas[i] == LOCK) begin
                        mLock[i] = 1; mCommas[i] = 0; mAcc[i] = 0; mRun[i] = 0;
                    end
                end
            end
            if (c) mErr[i] = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [LANES-1:0]    eSync, eLoss;
        logic [CW*LANES-1:0] eCnt;
        eCnt = '0;
        for (int i = 0; i < LANES; i++) begin
            eSync[i] = mLock[i];
            eLoss[i] = mLoss[i];
`ifdef RX_LINK_MON_ERR_CNT_EN
            eCnt[CW*i +: CW] = CW'(mErr[i]);
`endif
        end
        check({tag, "/laneSync"}, laneSync, eSync);
        check({tag, "/allSync"}, allSync, &eSync);
        check({tag, "/loss"}, loss, eLoss);
        check({tag, "/errCount"}, errCount, eCnt);
    endtask

    // Commas in the masked lanes, random bytes elsewhere.
    function automatic logic [8*LANES-1:0] mix(logic [LANES-1:0] commaMask);
        logic [8*LANES-1:0] d;
        d = $urandom;
        for (int i = 0; i < LANES; i++)
            if (commaMask[i]) d[8*i +: 8] = 8'hBC;
        return d;
    endfunction

    // One symbol cycle: drive off-edge, clock, advance model, sample at +1.
    task automatic cyc(input string tag, input logic [LANES-1:0] v, input logic [LANES-1:0] kk,
                       input logic [LANES-1:0] de, input logic [LANES-1:0] di,
                       input logic [8*LANES-1:0] d, input logic c);
        valid = v; k = kk; dec = de; disp = di; data = d; clr = c;
        @(posedge clk);
        modelStep(v, kk, de, di, d, c);
        #1 checkAll(tag);
    endtask

    initial begin
        logic [LANES-1:0] rv, rk, rd, rp, cm;
        modelReset();
        #1 rstN = 1'b0;
        #1 checkAll("reset");
        repeat (2) @(posedge clk);
        #1 checkAll("reset_hold");
        rstN = 1'b1;

        // Lane 0 alone sees four commas; others see clean data.
        for (int n = 0; n < 4; n++) cyc("lock0", 4'hF, 4'h1, 4'h0, 4'h0, mix(4'h1), 1'b0);
        check("lock0_sync", laneSync, 4'b0001);
        check("lock0_all", allSync, 1'b0);

        // Lock every lane.
        for (int n = 0; n < 4; n++) cyc("lockall", 4'hF, 4'hF, 4'h0, 4'h0, mix(4'hF), 1'b0);
        check("lockall_all", allSync, 1'b1);

        // Lane 2 decode errors x4 -> loss.
        for (int n = 0; n < 4; n++) cyc("loss2", 4'hF, 4'h0, 4'h4, 4'h0, mix(4'h0), 1'b0);
        check("loss2_pulse", loss, 4'b0100);
        check("loss2_sync", laneSync, 4'b1011);
`ifdef RX_LINK_MON_ERR_CNT_EN
        check("loss2_cnt", errCount[11:8], 4'd4);
`endif
        cyc("loss2_after", 4'h0, 4'h0, 4'h0, 4'h0, mix(4'h0), 1'b0);
        check("loss2_pulse_end", loss, 4'b0000);
        for (int n = 0; n < 4; n++) cyc("relock2", 4'h4, 4'h4, 4'h0, 4'h0, mix(4'h4), 1'b0);

        // Lane 1 leaky accumulator: 3 errors, 4 clean, 1 error stays; one more loses.
        for (int n = 0; n < 3; n++) cyc("leak_err", 4'hF, 4'h0, 4'h2, 4'h0, mix(4'h0), 1'b0);
        for (int n = 0; n < 4; n++) cyc("leak_clean", 4'hF, 4'h0, 4'h0, 4'h0, mix(4'h0), 1'b0);
        cyc("leak_err3", 4'hF, 4'h0, 4'h2, 4'h0, mix(4'h0), 1'b0);
        check("leak_held", laneSync[1], 1'b1);
        cyc("leak_err4", 4'hF, 4'h0, 4'h2, 4'h0, mix(4'h0), 1'b0);
        check("leak_lost", laneSync[1], 1'b0);
        check("leak_pulse", loss[1], 1'b1);

        // Lane 1: ACQ at 3 commas (with an idle gap), disparity error aborts.
        cyc("acq_c1", 4'h2, 4'h2, 4'h0, 4'h0, mix(4'h2), 1'b0);
        cyc("acq_idle", 4'h0, 4'h2, 4'h2, 4'h0, mix(4'h2), 1'b0);
        cyc("acq_c2", 4'h2, 4'h2, 4'h0, 4'h0, mix(4'h2), 1'b0);
        cyc("acq_c3", 4'h2, 4'h2, 4'h0, 4'h0, mix(4'h2), 1'b0);
        cyc("acq_disp", 4'h2, 4'h2, 4'h0, 4'h2, mix(4'h2), 1'b0);
        for (int n = 0; n < 3; n++) cyc("acq_re", 4'h2, 4'h2, 4'h0, 4'h0, mix(4'h2), 1'b0);
        check("acq_not_yet", laneSync[1], 1'b0);
        cyc("acq_re4", 4'h2, 4'h2, 4'h0, 4'h0, mix(4'h2), 1'b0);
        check("acq_locked", laneSync[1], 1'b1);

        // Counter saturation and clear-over-error on lane 0.
        for (int n = 0; n < 20; n++) cyc("sat", 4'h1, 4'h0, 4'h1, 4'h0, mix(4'h0), 1'b0);
        cyc("sat_idle", 4'h0, 4'h0, 4'h1, 4'h0, mix(4'h0), 1'b0);
`ifdef RX_LINK_MON_ERR_CNT_EN
        check("sat_cnt", errCount[3:0], 4'd15);
`endif
        cyc("clr_err", 4'h1, 4'h0, 4'h1, 4'h0, mix(4'h0), 1'b1);
`ifdef RX_LINK_MON_ERR_CNT_EN
        check("clr_cnt", errCount, '0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rv = $urandom; rk = '0; rd = '0; rp = '0; cm = '0;
            for (int i = 0; i < LANES; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 5) begin cm[i] = 1'b1; rk[i] = 1'b1; end
                else if (r == 5) rd[i] = 1'b1;
                else if (r == 6) rp[i] = 1'b1;
                else rk[i] = $urandom_range(0, 1);
            end
            cyc("rand", rv, rk, rd, rp, mix(cm), ($urandom_range(0, 31) == 0));
        end

        // Async reset mid-cycle while all lanes are in SYNC.
        for (int n = 0; n < 4; n++) cyc("prereset", 4'hF, 4'hF, 4'h0, 4'h0, mix(4'hF), 1'b0);
        check("prereset_all", allSync, 1'b1);
        #2 rstN = 1'b0;
        modelReset();
        #1 checkAll("async_reset");
        check("async_reset_sync", laneSync, 4'b0000);
        @(posedge clk);
        #1 checkAll("reset_edge");
        #2 rstN = 1'b1;
        for (int n = 0; n < 4; n++) cyc("post_reset", 4'hF, 4'hF, 4'h0, 4'h0, mix(4'hF), 1'b0);
        check("post_reset_all", allSync, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
